trace_logger: RTL and testbench

//   Captures CPU bus cycles (addr, data, rnw, sync) on the cpu_clken strobe into a record FIFO.

---
 rtl/trace_logger_pkg.sv | 36 +++
 rtl/trace_uart_tx.sv | 54 +++++
 rtl/trace_logger.sv | 124 ++++++++++++
 tb/tb_trace_logger.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_logger_pkg.sv
// Shared constants, record layout and serialiser state encoding for the bus trace logger.
package trace_pkg;

  localparam logic [3:0]  TRACE_MAGIC = 4'hA;
  localparam int unsigned REC_W       = 32;
  localparam int unsigned REC_BYTES   = 4;
  localparam int unsigned BYTE_W      = 8;

  // Record layout, MSB byte first on the wire:
  // [31:28] magic, [27] ovf, [26] 0, [25] sync, [24] rnw, [23:8] addr, [7:0] data
  localparam int unsigned REC_OVF_BIT  = 27;
  localparam int unsigned REC_SYNC_BIT = 25;
  localparam int unsigned REC_RNW_BIT  = 24;
  localparam int unsigned REC_ADDR_LSB = 8;
  localparam int unsigned REC_DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [REC_W-1:0] pack_record(
    input logic        ovf,
    input logic        sync,
    input logic        rnw,
    input logic [15:0] addr,
    input logic [7:0]  data
  );
    return {TRACE_MAGIC, ovf, 1'b0, sync, rnw, addr, data};
  endfunction

endpackage

// File: rtl/trace_uart_tx.sv
// 8N1 transmitter: owns the bit-period counter, the 10-bit frame shift and the txd pin.
module trace_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       bit_end,
  output logic       done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame;
  logic          active;

  assign bit_end = active && (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign done    = bit_end && (bit_cnt == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd     <= 1'b1;
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      frame   <= '1;
    end else if (load) begin
      txd     <= 1'b0;
      frame   <= {1'b1, tx_byte, 1'b0};
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          // frame[0] is the bit currently on txd; advance to the next one
          txd     <= frame[1];
          frame   <= {1'b1, frame[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/trace_logger.sv
// Captures CPU bus cycles into a record FIFO and streams each record as four 8N1 bytes on txd.
module trace_logger
  import trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned SYNC_ONLY    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cyc_valid,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_data,
  input  logic        cyc_rnw,
  input  logic        cyc_sync,
  output logic        txd,
  output logic        busy,
  output logic [7:0]  dropped
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [REC_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full, accept, push, drop, pending_ovf;
  logic [REC_W-1:0] rec_in, shift_rec;
  logic [1:0]       byte_idx;
  logic [2:0]       dbit;
  logic             pop, load, bit_end, done;
  tx_state_e        state, state_nx;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign accept = cyc_valid && enable && ((SYNC_ONLY == 0) || cyc_sync);
  // Full comes from the registered pointers, so a same-edge pop never rescues a push
  assign push   = accept && !full;
  assign drop   = accept && full;
  assign rec_in = pack_record(pending_ovf, cyc_sync, cyc_rnw, cyc_addr, cyc_data);
  assign busy   = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending_ovf <= 1'b0;
      dropped     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        pending_ovf <= 1'b1;
        if (dropped != 8'hFF) dropped <= dropped + 8'd1;
      end else if (push) begin
        pending_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!empty) state_nx = POP;
      POP:   state_nx = LOAD;
      LOAD:  state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && dbit == 3'd7) state_nx = STOP;
      STOP:
        if (done) begin
          if (byte_idx != 2'(REC_BYTES - 1)) state_nx = LOAD;
          else if (!empty)                   state_nx = POP;
          else                               state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop  = (state == POP);
    load = (state == LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_rec <= '0;
      byte_idx  <= '0;
      dbit      <= '0;
    end else begin
      if (pop) begin
        shift_rec <= mem[rd_ptr[FIFO_AW-1:0]];
        byte_idx  <= '0;
      end
      if (state == START && bit_end) dbit <= '0;
      if (state == DATA && bit_end)  dbit <= dbit + 3'd1;
      if (state == STOP && done && byte_idx != 2'(REC_BYTES - 1)) begin
        byte_idx  <= byte_idx + 2'd1;
        shift_rec <= shift_rec << BYTE_W;
      end
    end
  end

  trace_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .tx_byte (shift_rec[REC_W-1 -: BYTE_W]),
    .txd     (txd),
    .bit_end (bit_end),
    .done    (done)
  );

endmodule

// File: tb/tb_trace_logger.sv
// Directed bench for trace_logger: byte scoreboard fed by stimulus, drained by a UART decoder.
module tb_trace_logger;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 2;

  logic        clk = 1'b0;
  logic        reset, enable, valid_m, valid_s, rnw, sync;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        txd_m, busy_m, txd_s, busy_s;
  logic [7:0]  dropped_m, dropped_s;

  always #5 clk = ~clk;

  trace_logger #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .SYNC_ONLY(0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .cyc_valid(valid_m),
    .cyc_addr(addr), .cyc_data(data), .cyc_rnw(rnw), .cyc_sync(sync),
    .txd(txd_m), .busy(busy_m), .dropped(dropped_m)
  );

  trace_logger #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .SYNC_ONLY(1)) u_dut_sync (
    .clk(clk), .reset(reset), .enable(enable), .cyc_valid(valid_s),
    .cyc_addr(addr), .cyc_data(data), .cyc_rnw(rnw), .cyc_sync(sync),
    .txd(txd_s), .busy(busy_s), .dropped(dropped_s)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  bit         sel = 1'b0;
  bit         m_povf = 1'b0;
  int         m_drop = 0;

  bit         rx_busy = 1'b0;
  int         rx_bit, rx_cnt, rx_frames = 0;
  int         rx_first_start = -1;
  int         rx_last_done = 0;
  logic       rx_val, rx_ok;
  logic [7:0] rx_byte;
  logic       rx_line;

  always @(posedge clk) cyc <= cyc + 1;
  assign rx_line = sel ? txd_s : txd_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples every clock of every bit so that a bit of the wrong length is caught
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (rx_line === 1'b0) begin
          rx_busy = 1'b1; rx_bit = 0; rx_cnt = 1; rx_val = 1'b0; rx_ok = 1'b1; rx_byte = '0;
          if (rx_first_start < 0) rx_first_start = cyc;
        end
      end else begin
        if (rx_cnt == 0) begin
          rx_val = rx_line;
          if (rx_bit >= 1 && rx_bit <= 8) rx_byte[rx_bit-1] = rx_line;
        end else if (rx_line !== rx_val) begin
          rx_ok = 1'b0;
        end
        rx_cnt++;
        if (rx_cnt == CPB) begin
          rx_cnt = 0;
          rx_bit++;
          if (rx_bit == 10) begin
            rx_busy = 1'b0;
            rx_last_done = cyc;
            rx_frames++;
            chk("bit_timing", rx_ok, 1);
            chk("stop_bit", rx_val, 1);
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $error("FAIL byte_unexpected: observed=%0h expected=none", rx_byte);
            end else begin
              chk("rx_byte", rx_byte, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // kind: 0 = accepted, 1 = dropped (FIFO full), 2 = ignored
  task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic r,
                        input logic s, input int kind);
    addr = a; data = d; rnw = r; sync = s;
    if (sel) valid_s = 1'b1; else valid_m = 1'b1;
    if (kind == 0) begin
      exp_q.push_back({4'hA, (sel ? 1'b0 : m_povf), 1'b0, s, r});
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
      exp_q.push_back(d);
      if (!sel) m_povf = 1'b0;
    end else if (kind == 1) begin
      m_povf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    @(posedge clk); #1;
    valid_m = 1'b0;
    valid_s = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((busy_m || busy_s || rx_busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, n < 3000, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int e;
    int n;
    int f0;
    reset = 1'b1; enable = 1'b1; valid_m = 1'b0; valid_s = 1'b0;
    rnw = 1'b0; sync = 1'b0; addr = '0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", txd_m, 1);
    chk("reset_busy", busy_m, 0);
    chk("reset_dropped", dropped_m, 0);
    chk("reset_txd_sync", txd_s, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single read record, latency and busy fall
    e = cyc;
    strobe(16'hC123, 8'h5A, 1'b1, 1'b1, 0);
    chk("busy_after_accept", busy_m, 1);
    n = 0;
    while (busy_m !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_in_time", n < 1000, 1);
    chk("first_start_latency", rx_first_start, e + 4);
    chk("busy_fall_after_stop", cyc, rx_last_done + 1);
    wait_drain("t1");

    // 2: write record
    strobe(16'h0010, 8'hFF, 1'b0, 1'b0, 0);
    wait_drain("t2");

    // 3: six back-to-back strobes, sixth dropped, next record flags overflow
    for (int i = 0; i < 6; i++)
      strobe(16'h3000 + 16'(i), 8'(i * 17), 1'(i), 1'b1, (i < 5) ? 0 : 1);
    wait_drain("t3");
    chk("t3_dropped", dropped_m, 1);
    strobe(16'hBEEF, 8'h42, 1'b1, 1'b0, 0);
    wait_drain("t3_ovf");

    // 4: three rounds of 140 drops each, counter must saturate
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 145; i++)
        strobe(16'(r * 256 + i), 8'(i), 1'(i), 1'b1, (i < 5) ? 0 : 1);
      wait_drain("t4");
      chk("t4_dropped", dropped_m, m_drop);
    end
    chk("t4_saturated", dropped_m, 8'hFF);

    // 5: sync-only instance ignores non-sync strobes; enable=0 queues nothing
    sel = 1'b1;
    for (int i = 0; i < 6; i++)
      strobe(16'h5000 + 16'(i), 8'hC0 + 8'(i), 1'b1, ~1'(i), (i % 2 == 0) ? 0 : 2);
    wait_drain("t5");
    chk("t5_sync_dropped", dropped_s, 0);
    sel = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) strobe(16'h6000 + 16'(i), 8'h11, 1'b1, 1'b1, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_disabled_busy", busy_m, 0);
    chk("t5_disabled_txd", txd_m, 1);
    enable = 1'b1;
    wait_drain("t5_dis");

    // 6: reset while B2 (all-zero data bits) is on the wire
    f0 = rx_frames;
    strobe(16'h1200, 8'h77, 1'b1, 1'b1, 0);
    n = 0;
    while (!(rx_frames == f0 + 2 && rx_busy && rx_bit == 3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_b2", n < 1000, 1);
    chk("t6_txd_low_before_reset", txd_m, 0);
    reset = 1'b1;
    #1;
    chk("t6_txd_async", txd_m, 1);
    chk("t6_busy_async", busy_m, 0);
    chk("t6_dropped_clear", dropped_m, 0);
    exp_q.delete();
    m_povf = 1'b0;
    m_drop = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    strobe(16'h5678, 8'h9A, 1'b0, 1'b1, 0);
    wait_drain("t6");
    chk("t6_dropped_after", dropped_m, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
